// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: program counter and fetch buffer in front of the
// instruction memory. Each cycle the word at pc is captured together with its
// address into a small FIFO that feeds decode over a valid/ready handshake.
// A redirect from execute flushes the buffer and reloads pc.
// Optional build macro FETCH_JUMP_PREDICT_EN: when defined, unconditional
// jump words are followed at fetch time instead of waiting for a redirect.
module instruction_fetch_unit #(
    parameter int            AW         = 12,
    parameter int            IW         = 19,
    parameter logic [AW-1:0] RESET_PC   = '0,
    parameter int            FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_instr,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          if_valid,
    output logic [IW-1:0] if_instr,
    output logic [AW-1:0] if_pc,
    input  logic          id_ready
);

    // FIFO_DEPTH is a power of two, so pointers wrap naturally at PW bits.
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [AW-1:0] pc_q, pc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [AW-1:0] pc_buf   [FIFO_DEPTH];
    logic [IW-1:0] instr_buf[FIFO_DEPTH];

    logic          full;
    logic          not_empty;
    logic          pop;
    logic          push;
    logic [AW-1:0] pc_after_push;

    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign not_empty = (count_q != '0);

    // Redirect squashes both the head handshake and the current fetch.
    assign pop  = not_empty & id_ready & ~redirect_valid;
    assign push = ~redirect_valid & (~full | pop);

`ifdef FETCH_JUMP_PREDICT_EN
    logic is_jump;
    assign is_jump = (imem_instr[IW-1:IW-3] == 3'b111) &&
                     (imem_instr[IW-4:IW-7] == 4'b0000);
    assign pc_after_push = is_jump ? imem_instr[AW-1:0] : pc_q + AW'(1);
`else
    assign pc_after_push = pc_q + AW'(1);
`endif

    // Next-state for pc, pointers and occupancy; redirect overrides all.
    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_after_push;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state; asynchronous reset empties the buffer at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Buffer storage; contents are only observed through count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_buf[wr_ptr_q]    <= pc_q;
            instr_buf[wr_ptr_q] <= imem_instr;
        end
    end

    assign imem_addr = pc_q;
    assign if_valid  = not_empty & ~redirect_valid;
    assign if_instr  = if_valid ? instr_buf[rd_ptr_q] : '0;
    assign if_pc     = if_valid ? pc_buf[rd_ptr_q]    : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized and directed bench for the fetch
// unit, checked against a queue-based transaction model of the fetch buffer.
module tb_instruction_fetch_unit;

    localparam int AW    = 12;
    localparam int IW    = 19;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_instr;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          if_valid;
    logic [IW-1:0] if_instr;
    logic [AW-1:0] if_pc;
    logic          id_ready;

    logic [AW-1:0] imem_addr2;
    logic [IW-1:0] imem_instr2;
    logic          if_valid2;
    logic [IW-1:0] if_instr2;
    logic [AW-1:0] if_pc2;

    logic [IW-1:0] mem [4096];

    int checks = 0;
    int errors = 0;

    // Model state: queue of {pc, instr} and the fetch pointer.
    logic [AW+IW-1:0] q[$];
    logic [AW-1:0]    mpc;
    logic             exp_valid;
    logic [AW-1:0]    exp_pc;
    logic [IW-1:0]    exp_instr;
    logic [AW-1:0]    exp_addr;

    always #5 clk = ~clk;

    assign imem_instr  = mem[imem_addr];
    assign imem_instr2 = mem[imem_addr2];

    instruction_fetch_unit #(.AW(AW), .IW(IW), .RESET_PC(12'h000), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready)
    );

    instruction_fetch_unit #(.AW(AW), .IW(IW), .RESET_PC(12'hFFE), .FIFO_DEPTH(DEPTH)) u_dut_wrap (
        .clk(clk), .rst(rst), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
        .redirect_valid(1'b0), .redirect_pc(12'h000),
        .if_valid(if_valid2), .if_instr(if_instr2), .if_pc(if_pc2), .id_ready(1'b1)
    );

    function automatic logic [AW-1:0] next_pc(input logic [AW-1:0] pc, input logic [IW-1:0] w);
`ifdef FETCH_JUMP_PREDICT_EN
        if (w[18:12] == 7'b1110000) return w[11:0];
`endif
        return pc + 12'd1;
    endfunction

    // Apply inputs for one cycle, derive expected outputs, move to the sampling edge.
    task automatic tick(input logic rv, input logic [AW-1:0] rpc, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        exp_valid = (q.size() != 0) && !rv;
        exp_pc    = exp_valid ? q[0][AW+IW-1:IW] : '0;
        exp_instr = exp_valid ? q[0][IW-1:0] : '0;
        exp_addr  = mpc;
        @(negedge clk);
    endtask

    // Apply the clock edge to the model and to the DUT.
    task automatic advance();
        logic was_full;
        logic mpop;
        was_full = (q.size() == DEPTH);
        mpop     = exp_valid && id_ready;
        if (redirect_valid) begin
            q.delete();
            mpc = redirect_pc;
        end else begin
            if (mpop) void'(q.pop_front());
            if (!was_full || mpop) begin
                q.push_back({mpc, mem[mpc]});
                mpc = next_pc(mpc, mem[mpc]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b0;
        q.delete();
        mpc = 12'h000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b1;
        @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", if_valid); end
        checks++; if (if_pc !== 12'h000) begin errors++; $display("FAIL reset_pc got %h exp 000", if_pc); end
        checks++; if (if_instr !== 19'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", if_instr); end
        checks++; if (imem_addr !== 12'h000) begin errors++; $display("FAIL reset_addr got %h exp 000", imem_addr); end
        checks++; if (imem_addr2 !== 12'hFFE) begin errors++; $display("FAIL reset_addr2 got %h exp FFE", imem_addr2); end
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        mpc = 12'h000;
    endtask

    task automatic test_startup();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            tick(1'b0, '0, 1'b1);
            checks++; if (if_valid !== exp_valid || if_pc !== exp_pc) begin
                errors++; $display("FAIL startup_model c=%0d got v=%0b pc=%h exp v=%0b pc=%h", c, if_valid, if_pc, exp_valid, exp_pc);
            end
            if (c == 1) begin
                checks++; if (if_valid !== 1'b1 || if_pc !== 12'h000) begin
                    errors++; $display("FAIL startup_c1 got v=%0b pc=%h exp v=1 pc=000", if_valid, if_pc);
                end
            end
            if (c == 3) begin
                checks++; if (if_pc !== 12'h002 || if_instr !== 19'b0000001101000101111) begin
                    errors++; $display("FAIL startup_c3 got pc=%h instr=%h exp pc=002 instr=%h", if_pc, if_instr, 19'b0000001101000101111);
                end
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] e;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, '0, 1'b1);
            if (c >= 1) begin
                e = 12'hFFE + 12'(c - 1);
                checks++; if (if_valid2 !== 1'b1 || if_pc2 !== e) begin
                    errors++; $display("FAIL wrap_seq c=%0d got v=%0b pc=%h exp v=1 pc=%h", c, if_valid2, if_pc2, e);
                end
            end
            advance();
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            tick(1'b0, '0, 1'b0);
            if (c >= 1) begin
                checks++; if (if_valid !== 1'b1 || if_pc !== 12'h000) begin
                    errors++; $display("FAIL stall_head c=%0d got v=%0b pc=%h exp v=1 pc=000", c, if_valid, if_pc);
                end
            end
            if (c >= 2) begin
                checks++; if (imem_addr !== 12'h002) begin
                    errors++; $display("FAIL stall_addr c=%0d got %h exp 002", c, imem_addr);
                end
            end
            advance();
        end
        for (int c = 0; c < 7; c++) begin
            tick(1'b0, '0, 1'b1);
            checks++; if (if_valid !== 1'b1 || if_pc !== 12'(c)) begin
                errors++; $display("FAIL drain_seq c=%0d got v=%0b pc=%h exp v=1 pc=%h", c, if_valid, if_pc, 12'(c));
            end
            advance();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (3) begin
            tick(1'b0, '0, 1'b0);
            advance();
        end
        tick(1'b1, 12'd15, 1'b1);
        checks++; if (if_valid !== 1'b0 || if_pc !== 12'h000) begin
            errors++; $display("FAIL redir_cycle got v=%0b pc=%h exp v=0 pc=000", if_valid, if_pc);
        end
        advance();
        tick(1'b0, '0, 1'b1);
        checks++; if (if_valid !== 1'b0 || imem_addr !== 12'd15) begin
            errors++; $display("FAIL redir_next got v=%0b addr=%h exp v=0 addr=00f", if_valid, imem_addr);
        end
        advance();
        tick(1'b0, '0, 1'b1);
        checks++; if (if_valid !== 1'b1 || if_pc !== 12'd15 || if_instr !== mem[15]) begin
            errors++; $display("FAIL redir_target got v=%0b pc=%h instr=%h exp v=1 pc=00f instr=%h", if_valid, if_pc, if_instr, mem[15]);
        end
        advance();
    endtask

    task automatic test_jump();
        logic [AW-1:0] e;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            tick(1'b0, '0, 1'b1);
            e = 12'(c - 1);
`ifdef FETCH_JUMP_PREDICT_EN
            if (c == 12) e = 12'd15;
            if (c == 13) e = 12'd16;
`endif
            if (c >= 9) begin
                checks++; if (if_valid !== 1'b1 || if_pc !== e) begin
                    errors++; $display("FAIL jump_seq c=%0d got v=%0b pc=%h exp v=1 pc=%h", c, if_valid, if_pc, e);
                end
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (3) begin
            tick(1'b0, '0, 1'b0);
            advance();
        end
        checks++; if (if_valid !== 1'b1) begin
            errors++; $display("FAIL async_pre got v=%0b exp 1", if_valid);
        end
        rst = 1'b1;
        #1;
        checks++; if (if_valid !== 1'b0 || if_pc !== 12'h000 || imem_addr !== 12'h000) begin
            errors++; $display("FAIL async_rst got v=%0b pc=%h addr=%h exp v=0 pc=000 addr=000", if_valid, if_pc, imem_addr);
        end
        checks++; if (imem_addr2 !== 12'hFFE) begin
            errors++; $display("FAIL async_rst2 got addr=%h exp FFE", imem_addr2);
        end
        q.delete();
        mpc = 12'h000;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_random();
        logic          rv;
        logic [AW-1:0] rpc;
        logic          rdy;
        int            bad;
        do_reset();
        bad = 0;
        for (int c = 0; c < 500; c++) begin
            rv  = ($urandom_range(0, 9) == 0);
            rpc = 12'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            tick(rv, rpc, rdy);
            checks++; if (if_valid !== exp_valid || if_pc !== exp_pc || if_instr !== exp_instr || imem_addr !== exp_addr) begin
                errors++;
                if (bad < 10) $display("FAIL random c=%0d got v=%0b pc=%h i=%h a=%h exp v=%0b pc=%h i=%h a=%h",
                                       c, if_valid, if_pc, if_instr, imem_addr, exp_valid, exp_pc, exp_instr, exp_addr);
                bad++;
            end
            advance();
        end
    endtask

    initial begin
        logic [IW-1:0] w;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b0;
        mpc = 12'h000;
        for (int i = 0; i < 4096; i++) begin
            w = IW'($urandom);
            if (w[18:12] == 7'b1110000) w[15] = 1'b1;
            mem[i] = w;
        end
        mem[2]  = 19'b0000001101000101111;
        mem[10] = 19'b1110000000000001111;

        test_reset();
        test_startup();
        test_wrap();
        test_full_stall();
        test_redirect();
        test_jump();
        test_async_reset();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
